output_pkt_arbiter: RTL and testbench
=====================================

Name: output_pkt_arbiter

Overview:
Round-robin packet arbiter that shares the single 16-bit write port of output_fifo between N result sources in the md5crypt pkt_comm domain. Packets stay atomic: once a source is granted, it holds the port until its last word is written. The block sits between the per-core result packet generators and output_fifo (din/wr_en/full). It also supplies a packet counter and a sticky length-violation error, which feeds pkt_comm_status.

Parameters:
N, 4, number of requesters (2..8, power of two not required)
MAX_PKT_WORDS, 256, maximum words per packet, last word included (2..65535)

Ports:
CLK  input  1  PKT_COMM_CLK domain clock
RESET_N  input  1  asynchronous active-low reset
en  input  1  allow new grants; checked only in IDLE
in_data  input  16*N  requester i data at [16*i+15:16*i]
in_valid  input  N  requester i has a word available
in_last  input  N  current word of requester i ends its packet
in_ready  output  N  word of requester i is accepted this cycle
dout  output  16  to output_fifo din
wr_en  output  1  to output_fifo wr_en
full  input  1  from output_fifo full
grant_id  output  clog2(N) (min 1)  currently/last granted requester
busy  output  1  state==BUSY
err_pkt_len  output  1  sticky length violation
pkt_count  output  16  completed packets, wraps

Behaviour:
- Reset (async, RESET_N=0) sets: state IDLE, rr_ptr=0, grant_id=0, word_cnt=0, pkt_count=0, err_pkt_len=0, busy=0, in_ready=0, wr_en=0. dout=in_data of grant_id, combinational.
- States: IDLE, BUSY, ERROR.
- IDLE: if en & |in_valid, pick the first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... mod N. On the next edge: grant_id<=i, word_cnt<=0, state<=BUSY. in_ready=0 and wr_en=0 throughout IDLE.
- Arbitration latency: in_valid rises in cycle t (IDLE) -> grant in cycle t+1 -> earliest transfer in cycle t+1.
- BUSY outputs (g=grant_id):
  - xfer = in_valid[g] & ~full
  - wr_en = xfer
  - in_ready[g] = ~full
  - in_ready[j≠g] = 0
  - dout = in_data[16*g+:16]
  - Never write while full=1.
- BUSY on xfer & in_last[g]:
  - state<=IDLE, rr_ptr<=(g==N-1)?0:g+1, pkt_count<=pkt_count+1 (mod 2^16), word_cnt<=0.
  - At least one IDLE cycle separates packets, so the same requester re-requesting still obeys round-robin order.
- BUSY on xfer & ~in_last[g]:
  - word_cnt<=word_cnt+1.
  - If word_cnt==MAX_PKT_WORDS-1, the word is still written, then err_pkt_len<=1 and state<=ERROR.
- ERROR: terminal until reset. in_ready=0, wr_en=0, busy=0, err_pkt_len=1.
- Mid-packet behaviour:
  - en deassertion has no effect until the packet ends.
  - in_valid[g] may drop mid-packet; the block waits in BUSY without timeout.
- Requester contract: hold in_data/in_last stable while in_valid & ~in_ready. Non-granted requesters are ignored and may hold valid indefinitely.
- Simultaneous full rise and valid: full sampled in the same cycle wins, so no write occurs.
- Reset mid-packet: immediate return to reset values. The partial packet is abandoned; there is no recovery of it.
- word_cnt width: clog2(MAX_PKT_WORDS).

Test Plan:
- Req0 sends 3 words 0x1111,0x2222,0x3333 (last on 3rd), full=0 -> wr_en high 3 consecutive cycles starting 1 cycle after valid, dout matches, pkt_count=1, rr_ptr=1.
- Req0 and req2 both valid from reset with 2-word packets each, repeated -> grant order 0,2,0,2. One IDLE cycle between packets. No interleaving of words.
- Req1 4-word packet, full=1 during the 2nd and 3rd cycles of BUSY -> wr_en=0 and in_ready[1]=0 in those cycles, all 4 words written in order, none lost or duplicated.
- MAX_PKT_WORDS=4, req3 sends 5 words with no last -> first 4 written, err_pkt_len=1 after the 4th, 5th word never acked, later requests from any source ignored until RESET_N pulse.
- en=0 with req0 valid -> stays IDLE. Raise en -> grant next cycle. Drop en mid-packet -> packet completes, then no new grant.
- RESET_N low in the middle of a packet's 2nd word -> outputs return to reset values asynchronously. After release, a fresh req0 packet is arbitrated normally, with pkt_count starting again at 0.

Source files
------------

// File: rtl/output_pkt_arbiter.sv
// Round-robin arbiter sharing the single 16-bit output_fifo write port among N packet sources.
// Packets are atomic; also provides a wrapping packet counter and a sticky length-violation flag.
module output_pkt_arbiter #(
    parameter int N             = 4,
    parameter int MAX_PKT_WORDS = 256,
    localparam int GW           = (N > 1) ? $clog2(N) : 1,
    localparam int WCW          = $clog2(MAX_PKT_WORDS)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              en,
    input  logic [16*N-1:0]   in_data,
    input  logic [N-1:0]      in_valid,
    input  logic [N-1:0]      in_last,
    output logic [N-1:0]      in_ready,
    output logic [15:0]       dout,
    output logic              wr_en,
    input  logic              full,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic              err_pkt_len,
    output logic [15:0]       pkt_count
);

    typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]  grant_id_q, grant_id_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [15:0]    pkt_count_q, pkt_count_d;
    logic           err_q, err_d;

    logic           req_found;
    logic [GW-1:0]  req_sel;
    logic           xfer;

    // Search requesters starting at rr_ptr and wrapping, so the last winner gets lowest priority.
    always_comb begin
        int idx;
        logic [GW-1:0] cand;
        idx       = 0;
        cand      = '0;
        req_found = 1'b0;
        req_sel   = '0;
        for (int k = 0; k < N; k++) begin
            idx  = (int'(rr_ptr_q) + k) % N;
            cand = GW'(idx);
            if (!req_found && in_valid[cand]) begin
                req_found = 1'b1;
                req_sel   = cand;
            end
        end
    end

    assign xfer = (state_q == BUSY) && in_valid[grant_id_q] && !full;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        word_cnt_d  = word_cnt_q;
        pkt_count_d = pkt_count_q;
        err_d       = err_q;
        in_ready    = '0;
        wr_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && req_found) begin
                    grant_id_d = req_sel;
                    word_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                in_ready[grant_id_q] = !full;
                wr_en                = xfer;
                if (xfer) begin
                    if (in_last[grant_id_q]) begin
                        state_d     = IDLE;
                        rr_ptr_d    = (int'(grant_id_q) == N - 1) ? '0 : grant_id_q + 1'b1;
                        pkt_count_d = pkt_count_q + 16'd1;
                        word_cnt_d  = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        // The overlong word is still written before the block locks up.
                        if (word_cnt_q == WCW'(MAX_PKT_WORDS - 1)) begin
                            err_d   = 1'b1;
                            state_d = ERROR;
                        end
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            word_cnt_q  <= '0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            word_cnt_q  <= word_cnt_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
        end
    end

    assign dout        = in_data[int'(grant_id_q)*16 +: 16];
    assign grant_id    = grant_id_q;
    assign busy        = (state_q == BUSY);
    assign err_pkt_len = err_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_output_pkt_arbiter.sv
// Self-checking bench for output_pkt_arbiter: directed scenarios plus randomized packet
// traffic checked against a packet-level round-robin reference model.
module tb_output_pkt_arbiter;

    localparam int NREQ = 4;

    logic        clock;
    logic        resetN;
    logic        en;
    logic [63:0] inData;
    logic [3:0]  inValid;
    logic [3:0]  inLast;
    logic [3:0]  inReady;
    logic [15:0] dout;
    logic        wrEn;
    logic        full;
    logic [1:0]  grantId;
    logic        busy;
    logic        errPktLen;
    logic [15:0] pktCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        bit          first;
        bit          last;
    } word_t;

    typedef struct {
        int          src;
        logic [15:0] data;
        bit          last;
    } exp_t;

    // Pending words per requester, and the write stream the model predicts for them.
    word_t reqQ[NREQ][$];
    exp_t  expQ[$];
    int    modelPtr      = 0;
    int    modelPktCount = 0;

    output_pkt_arbiter #(.N(4), .MAX_PKT_WORDS(4)) dut (
        .CLK         (clock),
        .RESET_N     (resetN),
        .en          (en),
        .in_data     (inData),
        .in_valid    (inValid),
        .in_last     (inLast),
        .in_ready    (inReady),
        .dout        (dout),
        .wr_en       (wrEn),
        .full        (full),
        .grant_id    (grantId),
        .busy        (busy),
        .err_pkt_len (errPktLen),
        .pkt_count   (pktCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic e, input logic [3:0] v, input logic [3:0] l,
                                 input logic [63:0] d, input logic f);
        @(negedge clock);
        en      = e;
        inValid = v;
        inLast  = l;
        inData  = d;
        full    = f;
        #1;
    endtask

    function automatic logic [63:0] dataAt(input int slot, input logic [15:0] w);
        logic [63:0] d;
        d = '0;
        d[16*slot +: 16] = w;
        return d;
    endfunction

    task automatic pulseReset();
        en      = 1'b0;
        inValid = '0;
        inLast  = '0;
        full    = 1'b0;
        resetN  = 1'b0;
        #1;
        @(negedge clock);
        resetN        = 1'b1;
        modelPtr      = 0;
        modelPktCount = 0;
    endtask

    task automatic addPacket(input int src, input int len);
        word_t w;
        for (int k = 0; k < len; k++) begin
            w.data  = 16'($urandom);
            w.first = (k == 0);
            w.last  = (k == len - 1);
            reqQ[src].push_back(w);
        end
    endtask

    // Packet-level model: each grant goes to the next requester at or after the pointer
    // that still has packets, and its whole packet is emitted before anyone else.
    task automatic buildExpected();
        word_t cq[NREQ][$];
        word_t w;
        exp_t  e;
        int    ptr;
        int    sel;
        int    i;
        for (int r = 0; r < NREQ; r++) cq[r] = reqQ[r];
        expQ.delete();
        ptr = modelPtr;
        while (1) begin
            sel = -1;
            for (int k = 0; k < NREQ; k++) begin
                i = (ptr + k) % NREQ;
                if (sel < 0 && cq[i].size() > 0) sel = i;
            end
            if (sel < 0) break;
            do begin
                w      = cq[sel].pop_front();
                e.src  = sel;
                e.data = w.data;
                e.last = w.last;
                expQ.push_back(e);
            end while (!w.last);
            ptr = (sel + 1) % NREQ;
        end
    endtask

    task automatic runTraffic(input int maxCycles, input int fullPct, input int dropPct);
        int   cycles;
        bit   pendingIdle;
        logic [3:0] hs;
        exp_t e;
        buildExpected();
        cycles      = 0;
        pendingIdle = 0;
        while ((expQ.size() > 0 || pendingIdle) && cycles < maxCycles) begin
            @(negedge clock);
            en = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (reqQ[i].size() > 0) begin
                    inData[16*i +: 16] = reqQ[i][0].data;
                    inLast[i]          = reqQ[i][0].last;
                    inValid[i]         = reqQ[i][0].first ? 1'b1 : ($urandom_range(99) >= dropPct);
                end else begin
                    inData[16*i +: 16] = '0;
                    inLast[i]          = 1'b0;
                    inValid[i]         = 1'b0;
                end
            end
            full = ($urandom_range(99) < fullPct);
            #1;
            if (pendingIdle) begin
                checkOutput("idle_gap_busy", busy, 0);
                pendingIdle = 0;
            end
            checkOutput("no_write_when_full", wrEn & full, 0);
            hs = inValid & inReady;
            if (wrEn) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", wrEn, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("stream_dout", dout, e.data);
                    checkOutput("stream_grant", grantId, e.src);
                    checkOutput("stream_handshake", hs, 32'(4'b0001 << e.src));
                    if (e.last) begin
                        pendingIdle   = 1;
                        modelPktCount = modelPktCount + 1;
                        modelPtr      = (e.src + 1) % NREQ;
                    end
                end
            end else begin
                checkOutput("handshake_without_write", hs, 0);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
            end
            cycles++;
        end
        checkOutput("stream_drained", expQ.size(), 0);
        checkOutput("traffic_pkt_count", pktCount, modelPktCount & 16'hFFFF);
        for (int i = 0; i < NREQ; i++) reqQ[i].delete();
        @(negedge clock);
        inValid = '0;
        inLast  = '0;
        full    = 1'b0;
    endtask

    initial begin
        resetN  = 1'b0;
        en      = 1'b0;
        inData  = '0;
        inValid = '0;
        inLast  = '0;
        full    = 1'b0;
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_wr_en", wrEn, 0);
        checkOutput("reset_in_ready", inReady, 0);
        checkOutput("reset_grant", grantId, 0);
        checkOutput("reset_pkt_count", pktCount, 0);
        checkOutput("reset_err", errPktLen, 0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;

        // Req0 three-word packet.
        applyStimulus(1, 4'b0001, 4'b0000, dataAt(0, 16'h1111), 0);
        checkOutput("t1_idle_wr_en", wrEn, 0);
        checkOutput("t1_idle_ready", inReady, 0);
        applyStimulus(1, 4'b0001, 4'b0000, dataAt(0, 16'h1111), 0);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_w1_wr_en", wrEn, 1);
        checkOutput("t1_w1_dout", dout, 16'h1111);
        checkOutput("t1_w1_ready", inReady, 4'b0001);
        checkOutput("t1_grant", grantId, 0);
        applyStimulus(1, 4'b0001, 4'b0000, dataAt(0, 16'h2222), 0);
        checkOutput("t1_w2_wr_en", wrEn, 1);
        checkOutput("t1_w2_dout", dout, 16'h2222);
        applyStimulus(1, 4'b0001, 4'b0001, dataAt(0, 16'h3333), 0);
        checkOutput("t1_w3_wr_en", wrEn, 1);
        checkOutput("t1_w3_dout", dout, 16'h3333);
        applyStimulus(1, 4'b0000, 4'b0000, 64'h0, 0);
        checkOutput("t1_end_busy", busy, 0);
        checkOutput("t1_end_wr_en", wrEn, 0);
        checkOutput("t1_pkt_count", pktCount, 1);

        // Enable gating: no grant while en=0, grant after raise, en drop mid-packet ignored.
        applyStimulus(0, 4'b0001, 4'b0000, dataAt(0, 16'hAAAA), 0);
        checkOutput("t5_en0_busy_a", busy, 0);
        applyStimulus(0, 4'b0001, 4'b0000, dataAt(0, 16'hAAAA), 0);
        checkOutput("t5_en0_busy_b", busy, 0);
        applyStimulus(1, 4'b0001, 4'b0000, dataAt(0, 16'hAAAA), 0);
        checkOutput("t5_raise_still_idle", busy, 0);
        applyStimulus(0, 4'b0001, 4'b0000, dataAt(0, 16'hAAAA), 0);
        checkOutput("t5_granted", busy, 1);
        checkOutput("t5_w1_dout", dout, 16'hAAAA);
        checkOutput("t5_w1_wr_en", wrEn, 1);
        applyStimulus(0, 4'b0001, 4'b0001, dataAt(0, 16'hBBBB), 0);
        checkOutput("t5_w2_wr_en", wrEn, 1);
        checkOutput("t5_w2_dout", dout, 16'hBBBB);
        applyStimulus(0, 4'b0001, 4'b0000, dataAt(0, 16'hCCCC), 0);
        checkOutput("t5_no_regrant_a", busy, 0);
        applyStimulus(0, 4'b0001, 4'b0000, dataAt(0, 16'hCCCC), 0);
        checkOutput("t5_no_regrant_b", busy, 0);
        checkOutput("t5_no_regrant_wr", wrEn, 0);
        checkOutput("t5_pkt_count", pktCount, 2);

        // Req1 four-word packet with full asserted in the 2nd and 3rd busy cycles.
        applyStimulus(1, 4'b0010, 4'b0000, dataAt(1, 16'h1001), 0);
        checkOutput("t3_idle", busy, 0);
        applyStimulus(1, 4'b0010, 4'b0000, dataAt(1, 16'h1001), 0);
        checkOutput("t3_c1_wr_en", wrEn, 1);
        checkOutput("t3_c1_dout", dout, 16'h1001);
        checkOutput("t3_c1_ready", inReady, 4'b0010);
        applyStimulus(1, 4'b0010, 4'b0000, dataAt(1, 16'h1002), 1);
        checkOutput("t3_c2_full_wr_en", wrEn, 0);
        checkOutput("t3_c2_full_ready", inReady, 0);
        applyStimulus(1, 4'b0010, 4'b0000, dataAt(1, 16'h1002), 1);
        checkOutput("t3_c3_full_wr_en", wrEn, 0);
        checkOutput("t3_c3_full_ready", inReady, 0);
        applyStimulus(1, 4'b0010, 4'b0000, dataAt(1, 16'h1002), 0);
        checkOutput("t3_c4_wr_en", wrEn, 1);
        checkOutput("t3_c4_dout", dout, 16'h1002);
        applyStimulus(1, 4'b0010, 4'b0000, dataAt(1, 16'h1003), 0);
        checkOutput("t3_c5_dout", dout, 16'h1003);
        applyStimulus(1, 4'b0010, 4'b0010, dataAt(1, 16'h1004), 0);
        checkOutput("t3_c6_dout", dout, 16'h1004);
        checkOutput("t3_c6_wr_en", wrEn, 1);
        applyStimulus(1, 4'b0000, 4'b0000, 64'h0, 0);
        checkOutput("t3_end_busy", busy, 0);
        checkOutput("t3_pkt_count", pktCount, 3);

        // Req3 overlong packet: four words written, then terminal error.
        applyStimulus(1, 4'b1000, 4'b0000, dataAt(3, 16'h3001), 0);
        checkOutput("t4_idle", busy, 0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 4'b1000, 4'b0000, dataAt(3, 16'(16'h3000 + k)), 0);
            checkOutput("t4_word_wr_en", wrEn, 1);
            checkOutput("t4_word_dout", dout, 16'h3000 + k);
            checkOutput("t4_word_grant", grantId, 3);
        end
        applyStimulus(1, 4'b1000, 4'b0000, dataAt(3, 16'h3005), 0);
        checkOutput("t4_err", errPktLen, 1);
        checkOutput("t4_fifth_wr_en", wrEn, 0);
        checkOutput("t4_fifth_ready", inReady, 0);
        checkOutput("t4_busy", busy, 0);
        applyStimulus(1, 4'b1111, 4'b1111, 64'h4444_3333_2222_1111, 0);
        applyStimulus(1, 4'b1111, 4'b1111, 64'h4444_3333_2222_1111, 0);
        checkOutput("t4_locked_wr_en", wrEn, 0);
        checkOutput("t4_locked_ready", inReady, 0);
        checkOutput("t4_locked_busy", busy, 0);
        checkOutput("t4_locked_err", errPktLen, 1);
        checkOutput("t4_pkt_count", pktCount, 3);
        pulseReset();
        checkOutput("t4_err_cleared", errPktLen, 0);

        // Reset in the middle of a packet's second word, then a fresh packet.
        applyStimulus(1, 4'b0001, 4'b0000, dataAt(0, 16'h5001), 0);
        applyStimulus(1, 4'b0001, 4'b0000, dataAt(0, 16'h5001), 0);
        checkOutput("t6_w1_wr_en", wrEn, 1);
        applyStimulus(1, 4'b0001, 4'b0000, dataAt(0, 16'h5002), 0);
        checkOutput("t6_w2_wr_en", wrEn, 1);
        resetN = 1'b0;
        #1;
        checkOutput("t6_async_busy", busy, 0);
        checkOutput("t6_async_wr_en", wrEn, 0);
        checkOutput("t6_async_ready", inReady, 0);
        checkOutput("t6_async_pkt_count", pktCount, 0);
        inValid = '0;
        @(negedge clock);
        resetN = 1'b1;
        applyStimulus(1, 4'b0001, 4'b0000, dataAt(0, 16'h6001), 0);
        checkOutput("t6_fresh_idle", busy, 0);
        applyStimulus(1, 4'b0001, 4'b0000, dataAt(0, 16'h6001), 0);
        checkOutput("t6_fresh_w1", dout, 16'h6001);
        checkOutput("t6_fresh_w1_wr_en", wrEn, 1);
        applyStimulus(1, 4'b0001, 4'b0001, dataAt(0, 16'h6002), 0);
        checkOutput("t6_fresh_w2", dout, 16'h6002);
        applyStimulus(1, 4'b0000, 4'b0000, 64'h0, 0);
        checkOutput("t6_fresh_pkt_count", pktCount, 1);

        // Req0 and req2 both pending two 2-word packets from reset: order 0,2,0,2.
        pulseReset();
        begin
            word_t w;
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < 2; k++) begin
                    w.first = (k == 0);
                    w.last  = (k == 1);
                    w.data  = 16'(16'h0A00 + 2*p + k);
                    reqQ[0].push_back(w);
                    w.data  = 16'(16'h2C00 + 2*p + k);
                    reqQ[2].push_back(w);
                end
            end
        end
        runTraffic(200, 0, 0);

        // Randomized traffic with backpressure and mid-packet valid gaps.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                int npk;
                npk = $urandom_range(3);
                for (int p = 0; p < npk; p++) addPacket(i, $urandom_range(4, 1));
            end
            runTraffic(3000, 30, 25);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
